// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: drives imem, registers word+pc for decode, handles redirects and end-of-memory halt
module instr_fetch #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        halt,
  output logic        fault
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Highest word-aligned address that still lies fully inside memory.
  localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE) - 64'd4;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic        valid_n;
  logic [31:0] instr_n;
  logic [63:0] opc_n;
  logic        fault_n;

  logic take;
  logic target_ok;
  logic has_next;

  assign imem_addr = pc;
  assign halt      = (state == HALT);

  // Output register can load when empty or being drained by decode this cycle.
  assign take      = !out_valid || out_ready;
  // Aligned and below LAST_WORD means the whole 4-byte word is in memory; no wrap possible.
  assign target_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_WORD);
  // pc is aligned and in range, so pc + 4 cannot wrap.
  assign has_next  = (pc + 64'd4) <= LAST_WORD;

  // Register all fetch state; asynchronous reset restores the start-of-program view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 64'd0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= valid_n;
      out_instr <= instr_n;
      out_pc    <= opc_n;
      fault     <= fault_n;
    end
  end

  // Next-state: redirect beats fetch; a redirect always flushes the pending output.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = out_valid;
    instr_n = out_instr;
    opc_n   = out_pc;
    fault_n = fault;
    case (state)
      RUN, DRAIN: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (target_ok) begin
            pc_n    = redirect_pc;
            state_n = RUN;
          end else begin
            fault_n = 1'b1;
            state_n = HALT;
          end
        end else if (state == RUN) begin
          if (take) begin
            instr_n = imem_instr;
            opc_n   = pc;
            valid_n = 1'b1;
            if (has_next) begin
              pc_n = pc + 64'd4;
            end else begin
              state_n = DRAIN;
            end
          end
        end else if (out_valid && out_ready) begin
          valid_n = 1'b0;
          state_n = HALT;
        end
      end
      default: begin
        state_n = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed checks of instr_fetch against a transaction-level model
module tb_instr_fetch;

  localparam int unsigned MEM = 1024;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halt;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  // Model: where fetch will read next, what decode currently sees, and whether fetching is finished.
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_opc;
  logic [31:0] m_oinstr;
  logic        m_halt;
  logic        m_fault;
  logic        m_done;

  instr_fetch #(.MEM_SIZE(MEM), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halt(halt), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range or misaligned reads return a marker word.
  always_comb begin
    if (imem_addr < 64'(MEM) && imem_addr[1:0] == 2'b00) imem_instr = mem[imem_addr[9:2]];
    else imem_instr = 32'hDEAD_BEEF;
  end

  function automatic logic legal(input logic [63:0] t);
    return (t % 4 == 0) && (t + 3 < 64'(MEM));
  endfunction

  task automatic model_reset();
    m_pc = 64'd0; m_valid = 1'b0; m_opc = 64'd0; m_oinstr = 32'd0;
    m_halt = 1'b0; m_fault = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0] a;
    if (m_halt) return;
    if (redirect) begin
      m_valid = 1'b0;
      if (legal(redirect_pc)) begin
        m_pc = redirect_pc; m_done = 1'b0;
      end else begin
        m_fault = 1'b1; m_halt = 1'b1;
      end
    end else if (!m_done) begin
      if (!m_valid || out_ready) begin
        a = m_pc;
        m_valid = 1'b1; m_opc = m_pc; m_oinstr = mem[a[9:2]];
        if (m_pc + 7 < 64'(MEM)) m_pc = m_pc + 4;
        else m_done = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0; m_halt = 1'b1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;
    #1;
    checks++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'd0 || out_pc !== 64'd0) begin errors++; $display("FAIL reset_out got %h/%0d want 0/0", out_instr, out_pc); end
    checks++; if (halt !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", halt, fault); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential_and_backpressure();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== 32'(i)) begin
        errors++; $display("FAIL seq_%0d got v=%b pc=%0d instr=%0d want v=1 pc=%0d instr=%0d", i, out_valid, out_pc, out_instr, 4 * i, i);
      end
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'd8 || out_instr !== 32'd2 || imem_addr !== 64'd12) begin
        errors++; $display("FAIL stall_%0d got v=%b pc=%0d instr=%0d addr=%0d want 1/8/2/12", i, out_valid, out_pc, out_instr, imem_addr);
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 64'd12 || out_instr !== 32'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL release got pc=%0d instr=%0d v=%b want 12/3/1", out_pc, out_instr, out_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
      errors++; $display("FAIL redir_bubble got v=%b addr=%h want 0/40", out_valid, imem_addr);
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== 32'h10) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h instr=%h want 1/40/10", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_end_of_mem();
    logic [63:0] max_addr;
    logic [63:0] last_pc;
    int n;
    do_reset();
    out_ready = 1'b1;
    max_addr = 64'd0; last_pc = 64'd0; n = 0;
    while (!halt && n < 300) begin
      step();
      n++;
      if (imem_addr > max_addr) max_addr = imem_addr;
      if (out_valid) last_pc = out_pc;
    end
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL eom_timeout got halt=%b after %0d cycles want 1", halt, n); end
    checks++; if (n !== 257) begin errors++; $display("FAIL eom_cycles got %0d want 257", n); end
    checks++; if (last_pc !== 64'd1020 || max_addr !== 64'd1020) begin
      errors++; $display("FAIL eom_last got pc=%0d max_addr=%0d want 1020/1020", last_pc, max_addr);
    end
    checks++; if (fault !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL eom_flags got fault=%b v=%b want 0/0", fault, out_valid); end
    redirect = 1'b1; redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    step();
    checks++; if (halt !== 1'b1 || imem_addr !== 64'd1020 || out_valid !== 1'b0) begin
      errors++; $display("FAIL eom_redir_ignored got halt=%b addr=%0d v=%b want 1/1020/0", halt, imem_addr, out_valid);
    end
  endtask

  task automatic test_illegal_redirect();
    logic [63:0] bad [2];
    bad[0] = 64'h42; bad[1] = 64'h400;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      out_ready = 1'b1;
      repeat (3 - k) step();
      out_ready = 1'b0;
      redirect = 1'b1; redirect_pc = bad[k];
      step();
      redirect = 1'b0;
      checks++; if (halt !== 1'b1 || fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'(12 - 4 * k)) begin
        errors++; $display("FAIL illegal_%h got halt=%b fault=%b v=%b addr=%0d want 1/1/0/%0d", bad[k], halt, fault, out_valid, imem_addr, 12 - 4 * k);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || halt !== 1'b0 || fault !== 1'b0 || imem_addr !== 64'd0) begin
      errors++; $display("FAIL async_reset got v=%b h=%b f=%b addr=%0d want 0/0/0/0", out_valid, halt, fault, imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instr !== mem[0]) begin
      errors++; $display("FAIL async_resume got v=%b pc=%0d instr=%h want 1/0/%h", out_valid, out_pc, out_instr, mem[0]);
    end
  endtask

  task automatic test_random();
    int bad_cnt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    bad_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      out_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0: redirect_pc = 64'(4 * $urandom_range(0, 255));
        1: redirect_pc = 64'(MEM - 4 * $urandom_range(1, 6));
        2: redirect_pc = 64'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
        default: redirect_pc = 64'(MEM + 4 * $urandom_range(0, 1000));
      endcase
      step();
      redirect = 1'b0;
      checks++;
      if (imem_addr !== m_pc || out_valid !== m_valid || halt !== m_halt || fault !== m_fault ||
          (m_valid && (out_pc !== m_opc || out_instr !== m_oinstr))) begin
        errors++;
        if (bad_cnt < 10) $display("FAIL rand_cycle_%0d got addr=%0d v=%b pc=%0d instr=%h h=%b f=%b want addr=%0d v=%b pc=%0d instr=%h h=%b f=%b",
          c, imem_addr, out_valid, out_pc, out_instr, halt, fault, m_pc, m_valid, m_opc, m_oinstr, m_halt, m_fault);
        bad_cnt++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    model_reset();
    test_reset();
    test_sequential_and_backpressure();
    test_redirect();
    test_end_of_mem();
    test_illegal_redirect();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
